// File: rtl/defuzz9_seq.sv
// -----------------------------------------------------------------------------
// defuzz9_seq
//
// Sequential weighted-average defuzzifier for a 3x3 fuzzy rule grid
// (temperature x temperature-rate). Each rule k carries a firing strength w_k
// and a constant singleton output C_k; the crisp result is
//
//     y = trunc_toward_zero( sum(w_k * C_k) / sum(w_k) )
//
// computed with one multiply-accumulate per cycle followed by a 16-step
// restoring divider. Latency from the accept edge to out_valid is fixed at
// 26 clock edges regardless of the data, including the all-zero-weight case.
//
// Ports
//   clk        in   1   clock, all state changes on the rising edge
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   w00..w22 hold a valid weight set
//   in_ready   out  1   block is idle and will accept a weight set
//   w00..w22   in   16  unsigned rule firing strengths, row-major
//   y          out  16  signed crisp result, registered
//   den_zero   out  1   y is DEFAULT_OUT because every weight was zero
//   out_valid  out  1   y / den_zero are valid
//   out_ready  in   1   consumer accepts y
// -----------------------------------------------------------------------------
module defuzz9_seq #(
    parameter logic signed [15:0] C00         = -16'sd24576,
    parameter logic signed [15:0] C01         = -16'sd16384,
    parameter logic signed [15:0] C02         = 16'sd0,
    parameter logic signed [15:0] C10         = -16'sd8192,
    parameter logic signed [15:0] C11         = 16'sd0,
    parameter logic signed [15:0] C12         = 16'sd8192,
    parameter logic signed [15:0] C20         = 16'sd0,
    parameter logic signed [15:0] C21         = 16'sd16384,
    parameter logic signed [15:0] C22         = 16'sd24576,
    parameter logic signed [15:0] DEFAULT_OUT = 16'sd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        w00,
    input  logic [15:0]        w01,
    input  logic [15:0]        w02,
    input  logic [15:0]        w10,
    input  logic [15:0]        w11,
    input  logic [15:0]        w12,
    input  logic [15:0]        w20,
    input  logic [15:0]        w21,
    input  logic [15:0]        w22,
    output logic signed [15:0] y,
    output logic               den_zero,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDiv,
        StDone
    } state_e;

    state_e             r_state;

    // Latched weight set, row-major 00,01,02,10,...,22
    logic [15:0]        r_w [9];

    // ACC: term index 0..8, then 9 for the sign/magnitude load step.
    // DIV: iteration count 0..15.
    logic [3:0]         r_idx;

    logic signed [35:0] r_num;
    logic [19:0]        r_den;

    logic               r_neg;
    logic [35:0]        r_rem;
    logic [35:0]        r_dsr;
    logic [15:0]        r_quo;

    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_den_zero;
    logic signed [15:0] r_y;

    // -------------------------------------------------------------------------
    // Accumulate datapath: select the current term and form w_k * C_k
    // -------------------------------------------------------------------------
    logic [15:0]        w_wsel;
    logic signed [15:0] w_csel;
    logic signed [35:0] w_wext;
    logic signed [35:0] w_cext;
    logic signed [35:0] w_prod;
    logic [19:0]        w_den_next;

    always_comb begin
        w_wsel = r_w[0];
        w_csel = C00;
        case (r_idx)
            4'd0: begin w_wsel = r_w[0]; w_csel = C00; end
            4'd1: begin w_wsel = r_w[1]; w_csel = C01; end
            4'd2: begin w_wsel = r_w[2]; w_csel = C02; end
            4'd3: begin w_wsel = r_w[3]; w_csel = C10; end
            4'd4: begin w_wsel = r_w[4]; w_csel = C11; end
            4'd5: begin w_wsel = r_w[5]; w_csel = C12; end
            4'd6: begin w_wsel = r_w[6]; w_csel = C20; end
            4'd7: begin w_wsel = r_w[7]; w_csel = C21; end
            4'd8: begin w_wsel = r_w[8]; w_csel = C22; end
            default: begin w_wsel = 16'd0; w_csel = 16'sd0; end
        endcase
    end

    // Weight is unsigned: zero-extend it so the signed multiply stays exact.
    // |w * C| < 2^32, so the 36-bit product never truncates.
    assign w_wext     = {20'd0, w_wsel};
    assign w_cext     = {{20{w_csel[15]}}, w_csel};
    assign w_prod     = w_wext * w_cext;
    assign w_den_next = r_den + {4'd0, w_wsel};

    // -------------------------------------------------------------------------
    // Divide datapath: magnitude of the numerator and one restoring step
    // -------------------------------------------------------------------------
    logic [35:0]        w_num_neg;
    logic [35:0]        w_num_abs;
    logic               w_ge;
    logic [35:0]        w_rem_sub;
    logic [15:0]        w_quo_next;
    logic [15:0]        w_y_div;

    assign w_num_neg  = 36'd0 - r_num;
    assign w_num_abs  = r_num[35] ? w_num_neg : r_num;

    assign w_ge       = (r_rem >= r_dsr);
    assign w_rem_sub  = r_rem - r_dsr;
    assign w_quo_next = {r_quo[14:0], w_ge};

    // Quotient magnitude is at most 32768, so a negated 16'h8000 lands on
    // -32768 correctly and positive results never exceed 32767.
    assign w_y_div    = r_neg ? (16'd0 - w_quo_next) : w_quo_next;

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake and result outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            for (int i = 0; i < 9; i++) begin
                r_w[i] <= 16'd0;
            end
            r_idx       <= 4'd0;
            r_num       <= 36'sd0;
            r_den       <= 20'd0;
            r_neg       <= 1'b0;
            r_rem       <= 36'd0;
            r_dsr       <= 36'd0;
            r_quo       <= 16'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_den_zero  <= 1'b0;
            r_y         <= 16'sd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_w[0]     <= w00;
                        r_w[1]     <= w01;
                        r_w[2]     <= w02;
                        r_w[3]     <= w10;
                        r_w[4]     <= w11;
                        r_w[5]     <= w12;
                        r_w[6]     <= w20;
                        r_w[7]     <= w21;
                        r_w[8]     <= w22;
                        r_num      <= 36'sd0;
                        r_den      <= 20'd0;
                        r_idx      <= 4'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= StAcc;
                    end
                end

                StAcc: begin
                    if (r_idx == 4'd9) begin
                        // All nine terms are in; split the numerator into sign
                        // and magnitude and align the divisor for bit 15.
                        r_neg   <= r_num[35];
                        r_rem   <= w_num_abs;
                        r_dsr   <= {1'b0, r_den, 15'd0};
                        r_quo   <= 16'd0;
                        r_idx   <= 4'd0;
                        r_state <= StDiv;
                    end else begin
                        r_num <= r_num + w_prod;
                        r_den <= w_den_next;
                        r_idx <= r_idx + 4'd1;
                    end
                end

                StDiv: begin
                    // A zero divisor still runs all 16 steps to keep the
                    // latency fixed; its quotient is discarded below.
                    r_quo <= w_quo_next;
                    if (w_ge) begin
                        r_rem <= w_rem_sub;
                    end
                    r_dsr <= r_dsr >> 1;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'd15) begin
                        if (r_den == 20'd0) begin
                            r_y        <= DEFAULT_OUT;
                            r_den_zero <= 1'b1;
                        end else begin
                            r_y        <= $signed(w_y_div);
                            r_den_zero <= 1'b0;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign den_zero  = r_den_zero;

endmodule

// File: doc/defuzz9_seq.md
DEFUZZ9_SEQ -- requirements
Module: defuzz9_seq

Interface
REQ-001 SHALL: parameter C00, default -24576, signed 16-bit singleton output for rule (T neg, dT neg).
REQ-002 SHALL: parameter C01, default -16384, singleton for (neg, zero).
REQ-003 SHALL: parameter C02, default 0, singleton for (neg, pos).
REQ-004 SHALL: parameter C10, default -8192, singleton for (zero, neg).
REQ-005 SHALL: parameter C11, default 0, singleton for (zero, zero).
REQ-006 SHALL: parameter C12, default 8192, singleton for (zero, pos).
REQ-007 SHALL: parameter C20, default 0, singleton for (pos, neg).
REQ-008 SHALL: parameter C21, default 16384, singleton for (pos, zero).
REQ-009 SHALL: parameter C22, default 24576, singleton for (pos, pos).
REQ-010 SHALL: parameter DEFAULT_OUT, default 0, signed 16-bit result when all weights are zero.
REQ-011 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-012 SHALL: rst_n  input  1  reset, synchronous, active-low.
REQ-013 SHALL: in_valid  input  1  weight set w00..w22 is valid.
REQ-014 SHALL: in_ready  output  1  block accepts a new weight set.
REQ-015 SHALL: w00, w01, w02, w10, w11, w12, w20, w21, w22  input  16 each  unsigned rule firing strengths from the 3x3 min() rule grid.
REQ-016 SHALL: y  output  16  signed crisp result, registered.
REQ-017 SHALL: den_zero  output  1  result came from DEFAULT_OUT because the weight sum was 0.
REQ-018 SHALL: out_valid  input-side handshake output  1  y/den_zero valid.
REQ-019 SHALL: out_ready  input  1  consumer accepts y.

Function
REQ-020 SHALL: compute y = trunc_toward_zero( sum(w_k*C_k) / sum(w_k) ), k in row-major order 00,01,02,10,...,22.
REQ-021 SHALL: FSM states IDLE, ACC, DIV, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-022 SHALL: on in_valid&&in_ready edge latch all nine weights, clear num/den/index, go ACC; later input changes are ignored.
REQ-023 SHALL: ACC: one term per cycle for 9 cycles: num += w_k*C_k (signed 36-bit), den += w_k (unsigned 20-bit); no overflow possible at these widths.
REQ-024 SHALL: after 9th ACC cycle go DIV; take sign of num and |num|.
REQ-025 SHALL: DIV: 16-iteration restoring division of |num| by den, one quotient bit per cycle, MSB first; quotient fits 16 bits unsigned because |C_k| <= 32768.
REQ-026 SHALL: after 16th DIV cycle load y = sign-applied quotient, den_zero=0, go DONE.
REQ-027 SHALL: if den==0 the DIV state still runs 16 cycles (fixed latency), then y=DEFAULT_OUT, den_zero=1.
REQ-028 SHALL: latency fixed: out_valid rises exactly 26 clk edges after the accept edge (1 load + 9 ACC + 16 DIV).
REQ-029 SHALL: DONE holds y, den_zero, out_valid stable while out_ready=0, indefinitely.
REQ-030 SHALL: on out_valid&&out_ready edge go IDLE; in_ready=1 next cycle; no same-cycle accept (one transaction in flight).
REQ-031 SHALL: in_valid while not IDLE has no effect.

Reset
REQ-032 SHALL: rst_n=0 at a clk edge forces IDLE, in_ready=1, out_valid=0, y=0, den_zero=0, num=den=index=0, from any state including mid-ACC/DIV/DONE; in-flight transaction discarded.

Verification
REQ-033 SHALL: rst_n=0 two cycles -> in_ready=1, out_valid=0, y=0, den_zero=0.
REQ-034 SHALL: w22=0x4000, others 0 -> y=24576, den_zero=0, out_valid exactly 26 edges after accept.
REQ-035 SHALL: w00=0x6000, w10=0x2000 -> y=-20480; w21=w22=0x4000 -> y=20480.
REQ-036 SHALL: w00=1, w01=2 -> -57344/3 -> y=-19114 (truncation toward zero).
REQ-037 SHALL: all weights 0 -> y=DEFAULT_OUT (0), den_zero=1, same 26-cycle latency.
REQ-038 SHALL: out_ready=0 for 10 cycles in DONE with in_valid=1 -> y stable, in_ready=0, no accept; then out_ready=1 -> IDLE next edge; rst_n=0 mid-DIV -> IDLE next edge, out_valid never asserted for that set.
